// File: rtl/div_if.sv
// EX-stage <-> divider handshake bundle: operands and control in, result and stall request out.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             annul_i;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             ready_o;
  logic             stallreq_ex_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, annul_i,
    input  quotient_o, remainder_o, ready_o, stallreq_ex_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, annul_i,
    output quotient_o, remainder_o, ready_o, stallreq_ex_o
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; holds EX stalled until the result pulse.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic   clk,
  input  logic   rst,
  div_if.slave   bus
);

  localparam logic [1:0] S_FREE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_ZERO = 2'd2;
  localparam logic [1:0] S_END  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] raw_dvd;

  logic             go;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] prem_nxt;
  logic [WIDTH-1:0] dvd_nxt;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic is_signed);
    if (is_signed && (v < 0))
      return $unsigned(-v);
    return $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] v,
                                                input logic neg);
    logic signed [WIDTH-1:0] s;
    s = $signed(v);
    return neg ? $unsigned(-s) : v;
  endfunction

  assign go                = bus.start_i & ~bus.annul_i;
  assign bus.stallreq_ex_o = bus.start_i & ~bus.ready_o & ~bus.annul_i;

  // The dividend register doubles as the quotient: bits retire at the top as quotient bits enter below.
  always_comb begin
    shifted  = {prem, dvd[WIDTH-1]};
    trial    = shifted - {1'b0, dvs};
    q_bit    = ~trial[WIDTH];
    prem_nxt = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_nxt  = {dvd[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_FREE;
      count           <= '0;
      bus.ready_o     <= 1'b0;
      bus.quotient_o  <= '0;
      bus.remainder_o <= '0;
    end else begin
      bus.ready_o <= 1'b0;
      case (state)
        S_FREE: begin
          if (go) begin
            state <= (bus.divisor_i == '0) ? S_ZERO : S_ON;
            count <= '0;
          end
        end
        S_ON: begin
          if (!go) begin
            state <= S_FREE;
          end else begin
            count <= count + 1'b1;
            if (count == CNT_W'(WIDTH - 1)) begin
              state           <= S_END;
              bus.ready_o     <= 1'b1;
              bus.quotient_o  <= fix_sign(dvd_nxt, q_neg);
              bus.remainder_o <= fix_sign(prem_nxt, r_neg);
            end
          end
        end
        S_ZERO: begin
          if (!go) begin
            state <= S_FREE;
          end else begin
            state           <= S_END;
            bus.ready_o     <= 1'b1;
            bus.quotient_o  <= '1;
            bus.remainder_o <= raw_dvd;
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end

  // Operand capture and iteration datapath; only meaningful once the FSM has left FREE.
  always_ff @(posedge clk) begin
    if (state == S_FREE && go) begin
      dvd     <= mag(bus.dividend_i, bus.signed_i);
      dvs     <= mag(bus.divisor_i, bus.signed_i);
      q_neg   <= bus.signed_i & (bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1]);
      r_neg   <= bus.signed_i & bus.dividend_i[WIDTH-1];
      prem    <= '0;
      raw_dvd <= bus.dividend_i;
    end else if (state == S_ON) begin
      prem <= prem_nxt;
      dvd  <= dvd_nxt;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference model.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  time  rdy_time;

  div_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Must be called at a negedge; returns at negedge+1 of the ready cycle.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input string tag);
    logic [31:0] eq, er;
    int   lat;
    logic stall_ok;
    model(a, b, sgn, eq, er);
    bus.start_i    = 1'b1;
    bus.annul_i    = 1'b0;
    bus.signed_i   = sgn;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    lat      = -1;
    stall_ok = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) begin
        @(negedge clk);
        bus.dividend_i = $urandom;
        bus.divisor_i  = $urandom;
      end
      #1;
      if (bus.ready_o === 1'b1) begin
        lat = c;
        rdy_time = $time;
        break;
      end
      if (bus.stallreq_ex_o !== 1'b1) stall_ok = 1'b0;
    end
    chk({tag, "_lat"}, lat, (b == 0) ? 32'd2 : 32'd33);
    chk({tag, "_q"}, bus.quotient_o, eq);
    chk({tag, "_r"}, bus.remainder_o, er);
    chk({tag, "_stall_run"}, {31'd0, stall_ok}, 32'd1);
    chk({tag, "_stall_end"}, {31'd0, bus.stallreq_ex_o}, 32'd0);
  endtask

  task automatic release_op(input string tag);
    @(negedge clk);
    bus.start_i = 1'b0;
    #1;
    chk({tag, "_pulse1"}, {31'd0, bus.ready_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        sgn;
    logic        saw_rdy;
    time         t1;
    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.annul_i    = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_q", bus.quotient_o, 32'd0);
    chk("rst_r", bus.remainder_o, 32'd0);
    chk("rst_rdy", {31'd0, bus.ready_o}, 32'd0);
    chk("rst_stall", {31'd0, bus.stallreq_ex_o}, 32'd0);

    @(negedge clk); do_div(32'd100, 32'd7, 1'b0, "u100_7");          release_op("u100_7");
    @(negedge clk); do_div(32'hFFFF_FFF9, 32'd2, 1'b1, "sm7_2");     release_op("sm7_2");
    @(negedge clk); do_div(32'd7, 32'hFFFF_FFFE, 1'b1, "s7_m2");     release_op("s7_m2");
    @(negedge clk); do_div(32'h1234_5678, 32'd0, 1'b0, "dz_u");      release_op("dz_u");
    @(negedge clk); do_div(32'h8765_4321, 32'd0, 1'b1, "dz_s");      release_op("dz_s");
    @(negedge clk); do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "ovf"); release_op("ovf");
    @(negedge clk); do_div(32'hFFFF_FFF9, 32'd2, 1'b0, "u_big");     release_op("u_big");

    // Abort: annul in cycle 10, then verify no result pulse ever appears.
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.signed_i   = 1'b0;
    bus.dividend_i = 32'd5000;
    bus.divisor_i  = 32'd3;
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    #1;
    chk("abort_stall", {31'd0, bus.stallreq_ex_o}, 32'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    saw_rdy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.ready_o === 1'b1) saw_rdy = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_rdy", {31'd0, saw_rdy}, 32'd0);
    do_div(32'd1000, 32'd3, 1'b0, "post_abort"); release_op("post_abort");

    // Back-to-back: second start in the cycle right after END.
    @(negedge clk); do_div(32'd99, 32'd10, 1'b0, "b2b_a");
    t1 = rdy_time;
    @(negedge clk); do_div(32'hFFFF_FF9C, 32'd7, 1'b1, "b2b_b");
    chk("b2b_gap", 32'(rdy_time - t1), 32'd340);
    release_op("b2b_b");

    // Reset mid-iteration clears outputs and returns to FREE.
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.dividend_i = 32'd77777;
    bus.divisor_i  = 32'd13;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_q", bus.quotient_o, 32'd0);
    chk("mid_rst_r", bus.remainder_o, 32'd0);
    chk("mid_rst_rdy", {31'd0, bus.ready_o}, 32'd0);
    @(negedge clk); do_div(32'd77777, 32'd13, 1'b0, "post_rst"); release_op("post_rst");

    for (int i = 0; i < 10; i++) begin
      a   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case (i % 4)
        0: b = $urandom_range(1, 300);
        1: b = $urandom;
        2: b = (i == 2) ? 32'd0 : 32'hFFFF_FFFF - $urandom_range(0, 20);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      @(negedge clk); do_div(a, b, sgn, "rand"); release_op("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
- Sits beside the EX stage and is the requesting end of the stall protocol: it drives the EX stall request into the pipeline controller.
- While the request is high, the controller freezes PC/IF/ID/EX; the request drops in the cycle the result is presented, so EX advances on that edge.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start_i  input  1  EX holds a divide op; held high by the frozen EX stage until the result is taken
- signed_i  input  1  1 = DIV/REM, 0 = DIVU/REMU; sampled with start_i
- dividend_i  input  WIDTH  rs1; sampled on the start edge
- divisor_i  input  WIDTH  rs2; sampled on the start edge
- annul_i  input  1  flush/cancel of the in-flight op
- quotient_o  output  WIDTH  quotient; valid only while ready_o=1
- remainder_o  output  WIDTH  remainder; valid only while ready_o=1
- ready_o  output  1  one-cycle result-valid pulse
- stallreq_ex_o  output  1  stall request to the pipeline controller

Behaviour:
- One clock domain; every register updates on rising clk.
- Reset is synchronous, active-high and takes priority over all else. On reset:
  - state=FREE, counter=0
  - ready_o=0, quotient_o=0, remainder_o=0
- stallreq_ex_o = start_i & ~ready_o & ~annul_i. This is combinational, so there is no bubble cycle before the stall starts.
- States: FREE, ON, ZERO, END.
- FREE:
  - If start_i & ~annul_i & divisor_i==0, go to ZERO.
  - Else if start_i & ~annul_i, go to ON. On that edge:
    - latch signed_i;
    - latch |dividend| and |divisor| (two's-complement absolute value when signed, raw when unsigned);
    - latch the quotient sign (sign(a) xor sign(b)) and the remainder sign (sign(a));
    - clear the partial remainder and set counter=0.
  - Otherwise stay in FREE.
- ON, one iteration per cycle:
  - Shift {partial remainder, dividend} left by one.
  - Trial-subtract the divisor as a WIDTH+1-bit subtraction.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; else shift in 0.
  - counter++.
  - The edge that performs iteration WIDTH goes to END. Final sign correction (negate where the latched sign is 1) is applied into the output registers on that same edge.
- ZERO: for one cycle, go to END with quotient=all ones (0xFFFFFFFF) and remainder=original dividend_i (unmodified, per RISC-V).
- END:
  - ready_o=1 for exactly this one cycle and the outputs hold the result.
  - Go to FREE unconditionally next edge, with ready_o=0.
  - A back-to-back divide in the next EX instruction is picked up from FREE.
- Latency: start first seen in cycle 0. ready_o is high in cycle WIDTH+1 (33) for a normal divide, and in cycle 2 for divide-by-zero.
- Overflow (signed 0x80000000 / 0xFFFFFFFF) is not special-cased: the magnitude path yields quotient 0x80000000, remainder 0, which is correct per RISC-V.
- Abort: annul_i=1, or start_i=0, in ON/ZERO/END → FREE on the next edge. ready_o is 0 in that next cycle, and no result pulse is produced for the aborted op. In that cycle, stallreq_ex_o follows start_i & ~annul_i.
- In FREE and ON, ready_o=0 and quotient_o/remainder_o are don't-care (they hold their last value).
- Operands are captured at start. Changes on dividend_i/divisor_i during ON are ignored.

Test Plan:
- Unsigned: start, signed_i=0, 100/7 → stallreq high cycles 0–32; ready_o in cycle 33 with q=14, r=2; returns to FREE in cycle 34.
- Signed: −7/2 (0xFFFFFFF9, 2) → q=0xFFFFFFFD (−3), r=0xFFFFFFFF (−1). 7/−2 → q=−3, r=1.
- Divide by zero and overflow:
  - 0x12345678/0 → ready in cycle 2, q=0xFFFFFFFF, r=0x12345678.
  - signed 0x80000000/0xFFFFFFFF → q=0x80000000, r=0.
- Abort: start a divide, assert annul_i in cycle 10 → FREE next cycle; no ready_o pulse; stallreq_ex_o low while annul_i is high. A new op started afterwards completes correctly.
- Back-to-back and reset:
  - Two consecutive divides (start high again the cycle after END) → two ready pulses 34 cycles apart, each with the correct result.
  - rst asserted mid-ON → next cycle state=FREE and all outputs 0.
